serial_sub_mux: RTL and testbench
=================================

# serial_sub_mux

Bit-serial N-bit subtractor computing `a - b - bin` one bit per clock, LSB first. Each bit uses a full-subtractor cell whose difference and borrow are each selected by a 4:1 mux on the current `{a_bit, b_bit}` pair. It complements the team's mux-based full-adder datapath and serves as the area-cheap subtract path for multi-cycle arithmetic units. A start/busy/done handshake frames each operation, and results are held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH >= 2.
- `clk`  input  1: rising-edge clock; the block has one clock.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `start`  input  1: request pulse. Sampled only in IDLE.
- `a`  input  WIDTH: minuend, captured on the accepting edge.
- `b`  input  WIDTH: subtrahend, captured on the accepting edge.
- `bin`  input  1: borrow-in, captured on the accepting edge.
- `busy`  output  1: high while an operation is in progress (RUN state).
- `done`  output  1: one-cycle pulse marking that `diff` and `bout` have just been updated.
- `diff`  output  WIDTH: result register holding `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1: final borrow-out. It is 1 when `a < b + bin` (unsigned).

## Operation
- State machine has two states, IDLE and RUN.
  - IDLE → RUN when `start=1` at a clock edge. On that edge, `a`, `b` and `bin` are loaded into shift register `sa`, shift register `sb` and borrow flop `br`. The bit counter is cleared and the working difference register is cleared.
  - RUN → IDLE on the edge that processes bit WIDTH-1.
  - `start` is ignored while in RUN. There is no queueing and the latched operands are not disturbed.
- Per-bit cell, with select `{sa[0], sb[0]}`:
  - Difference mux inputs for selects 00/01/10/11 are `br`, `~br`, `~br`, `br`. This equals `sa[0]^sb[0]^br`.
  - Borrow mux inputs for selects 00/01/10/11 are `br`, `1`, `0`, `br`.
- Each RUN edge does the following:
  - Shift the difference bit into the MSB of the working register (shift right).
  - Shift `sa` and `sb` right by one.
  - Load `br` with the borrow mux output.
  - Increment the counter.
- On the final RUN edge:
  - `diff` is loaded with the completed working value, including the last bit.
  - `bout` is loaded with the final borrow.
  - `done` is set to 1.
  - `busy` is cleared.
- `diff` and `bout` change only on a completing edge. They hold their previous result throughout RUN.
- The counter is `$clog2(WIDTH)` bits wide. The terminal count is WIDTH-1, so no wrap-around occurs inside an operation.
- Reset values: state=IDLE, `busy=0`, `done=0`, `diff=0`, `bout=0`. All internal registers (`sa`, `sb`, `br`, counter, working register) are also 0.
- Reset asserted during RUN aborts the operation immediately, with no `done` pulse. Outputs return to their reset values.

## Timing
- Accept edge E0 (`start=1` in IDLE): `busy` goes to 1 after E0.
- Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- After edge E_WIDTH:
  - `busy=0`, `done=1`, and `diff`/`bout` are valid.
  - Latency from start to done is WIDTH edges, i.e. WIDTH+1 cycles counting from the cycle in which `start` is high.
- `done` is high for exactly one cycle and falls on the next edge.
- Back-to-back operation: `start=1` during the `done` cycle is accepted, because the state is IDLE. The new operation begins while the old `diff`/`bout` remain held. Throughput is one result per WIDTH+1 cycles.
- `start` held high continuously: a new operation is accepted on each cycle in which the block is in IDLE.
- Inputs `a`, `b` and `bin` may change freely after E0.

## Test plan
- WIDTH=8, a=100, b=37, bin=0, start pulsed:
  - `busy` is high for 8 cycles.
  - `done` pulses 8 edges after acceptance.
  - `diff`=63, `bout`=0.
- a=5, b=9, bin=0 → `diff`=0xFC, `bout`=1. a=0, b=0, bin=1 → `diff`=0xFF, `bout`=1. a=0xFF, b=0xFF, bin=0 → `diff`=0x00, `bout`=0.
- Start while busy: start a=200, b=1, then pulse `start` with a=3, b=7 three cycles later.
  - Exactly one `done` occurs.
  - Result is `diff`=199, `bout`=0.
- Back-to-back: assert `start` with new operands (a=10, b=20) in the `done` cycle of a 50-40 operation.
  - `diff`=10 is held for 8 cycles.
  - Then `diff`=0xF6 with `bout`=1.
- Reset mid-run: deassert `rst_n` 4 cycles into an operation.
  - Outputs go to 0 asynchronously (before the next clock edge).
  - No `done` pulse occurs.
  - After reset is released, a fresh 7-3 operation gives `diff`=4.
- Random regression: 1000 random (a, b, bin) at WIDTH=8 and WIDTH=16. Compare `{bout, diff}` against `{1'b0, a} - b - bin` (2's complement) and check `done` timing on every operation.

Source files
------------

// File: rtl/serial_sub_mux_if.sv
// Purpose : operand/result bundle for the bit-serial subtractor (start/busy/done framing).
// Latency : n/a (wiring only).
// Backpressure: none; the requester observes busy and waits for done.
// Ports   : start, a, b, bin (requester -> subtractor); busy, done, diff, bout (subtractor -> requester).
interface serial_sub_mux_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub_mux.sv
// Purpose : bit-serial a - b - bin, LSB first, one full-subtractor cell built from two 4:1 muxes.
// Latency : WIDTH edges from the accepting edge to the done pulse (WIDTH+1 cycles incl. the start cycle).
// Backpressure: start is only sampled in IDLE; a start during RUN is dropped, never queued.
// Ports   : clk, rst_n (async, active-low); bus = slave side of serial_sub_mux_if
//           (start/a/b/bin in, busy/done/diff/bout out). diff/bout hold until the next completion.
module serial_sub_mux #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_mux_if.slave    bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q;
    logic             done_q;

    logic             d_bit;
    logic             b_bit;
    logic             last;

    // Full-subtractor cell: both outputs are 4:1 muxes selected by the current operand bits.
    always_comb begin
        d_bit = br;
        b_bit = br;
        case ({sa[0], sb[0]})
            2'b00: begin d_bit = br;  b_bit = br;   end
            2'b01: begin d_bit = ~br; b_bit = 1'b1; end
            2'b10: begin d_bit = ~br; b_bit = 1'b0; end
            default: begin d_bit = br; b_bit = br;  end
        endcase
    end

    assign last = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            work   <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa   <= bus.a;
                        sb   <= bus.b;
                        br   <= bus.bin;
                        cnt  <= '0;
                        work <= '0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
                    work <= {d_bit, work[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= b_bit;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        diff_q <= {d_bit, work[WIDTH-1:1]};
                        bout_q <= b_bit;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub_mux.sv
// Purpose : self-checking bench for serial_sub_mux at WIDTH=8 and WIDTH=16 against an arithmetic model.
// Latency : expects done WIDTH edges after the accepting edge, busy high for WIDTH cycles.
// Backpressure: exercises start-while-busy (dropped) and start in the done cycle (accepted).
module tb_serial_sub_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] held_d [2];
    logic        held_b [2];

    always #5 clk = ~clk;

    serial_sub_mux_if #(.WIDTH(8))  if8 ();
    serial_sub_mux_if #(.WIDTH(16)) if16 ();

    serial_sub_mux #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_sub_mux #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [15:0] a,
                         input logic [15:0] b, input logic bi);
        if (w == 8) begin
            if8.start = s; if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bi;
        end else begin
            if16.start = s; if16.a = a; if16.b = b; if16.bin = bi;
        end
    endtask

    task automatic sample(input int w, output logic bz, output logic dn,
                          output logic [15:0] df, output logic bo);
        if (w == 8) begin
            bz = if8.busy; dn = if8.done; df = {8'h00, if8.diff}; bo = if8.bout;
        end else begin
            bz = if16.busy; dn = if16.done; df = if16.diff; bo = if16.bout;
        end
    endtask

    // Issues one operation at the current negedge and returns at the negedge where done is seen.
    task automatic run_op(input int w, input logic [15:0] a_in, input logic [15:0] b_in, input logic bi);
        int          k;
        int          n;
        int          nbusy;
        longint      r;
        logic [15:0] mask;
        logic [15:0] a;
        logic [15:0] b;
        logic        bz;
        logic        dn;
        logic        bo;
        logic [15:0] df;
        k     = (w == 16) ? 1 : 0;
        mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
        a     = a_in & mask;
        b     = b_in & mask;
        r     = longint'(a) - longint'(b) - longint'(bi);
        n     = 0;
        nbusy = 0;
        dn    = 1'b0;
        drive(w, 1'b1, a, b, bi);
        @(posedge clk);
        while (n < w + 10) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            sample(w, bz, dn, df, bo);
            if (dn) break;
            if (bz) nbusy++;
            check("hold_diff", 32'(df), 32'(held_d[k]));
            check("hold_bout", 32'(bo), 32'(held_b[k]));
        end
        check("done_seen", 32'(dn), 32'd1);
        check("latency", 32'(n), 32'(w + 1));
        check("busy_cycles", 32'(nbusy), 32'(w));
        check("busy_at_done", 32'(bz), 32'd0);
        check("diff", 32'(df), 32'(r & longint'(mask)));
        check("bout", 32'(bo), 32'(r < 0));
        held_d[k] = 16'(r & longint'(mask));
        held_b[k] = (r < 0);
    endtask

    task automatic idle_check(input int w);
        logic        bz;
        logic        dn;
        logic        bo;
        logic [15:0] df;
        @(negedge clk);
        sample(w, bz, dn, df, bo);
        check("done_one_cycle", 32'(dn), 32'd0);
        check("idle_busy", 32'(bz), 32'd0);
    endtask

    initial begin
        int ndone;
        held_d[0] = '0; held_d[1] = '0;
        held_b[0] = 1'b0; held_b[1] = 1'b0;
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_busy8", 32'(if8.busy), 32'd0);
        check("rst_done8", 32'(if8.done), 32'd0);
        check("rst_diff8", 32'(if8.diff), 32'd0);
        check("rst_bout8", 32'(if8.bout), 32'd0);
        check("rst_busy16", 32'(if16.busy), 32'd0);
        check("rst_diff16", 32'(if16.diff), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, each followed by a quiet cycle to see done fall.
        run_op(8, 16'd100, 16'd37, 1'b0); idle_check(8);
        run_op(8, 16'd5, 16'd9, 1'b0);    idle_check(8);
        run_op(8, 16'd0, 16'd0, 1'b1);    idle_check(8);
        run_op(8, 16'hFF, 16'hFF, 1'b0);  idle_check(8);

        // Start while busy: the second request lands mid-run and must be dropped.
        drive(8, 1'b1, 16'd200, 16'd1, 1'b0);
        @(posedge clk);
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
            if (i == 3) drive(8, 1'b1, 16'd3, 16'd7, 1'b0);
            if (i == 4) drive(8, 1'b0, 16'd3, 16'd7, 1'b0);
            if (if8.done) ndone++;
        end
        check("one_done", 32'(ndone), 32'd1);
        check("busy_diff", 32'(if8.diff), 32'd199);
        check("busy_bout", 32'(if8.bout), 32'd0);
        held_d[0] = 16'd199; held_b[0] = 1'b0;

        // Back-to-back: second start issued in the done cycle of the first.
        run_op(8, 16'd50, 16'd40, 1'b0);
        run_op(8, 16'd10, 16'd20, 1'b0);
        idle_check(8);

        // Reset four cycles into a run: outputs clear without waiting for a clock edge.
        drive(8, 1'b1, 16'd100, 16'd37, 1'b0);
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(if8.busy), 32'd0);
        check("arst_done", 32'(if8.done), 32'd0);
        check("arst_diff", 32'(if8.diff), 32'd0);
        check("arst_bout", 32'(if8.bout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (if8.done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        held_d[0] = '0; held_b[0] = 1'b0;
        held_d[1] = '0; held_b[1] = 1'b0;
        run_op(8, 16'd7, 16'd3, 1'b0);
        idle_check(8);

        // Random regression at both widths, with random gaps (gap 0 means back-to-back).
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 8 : 16;
            for (int t = 0; t < 1000; t++) begin
                run_op(w, 16'($urandom), 16'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) idle_check(w);
            end
            idle_check(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
